sample_avg_core: RTL and testbench
==================================

# sample_avg_core

Running-average block: accumulates every valid `WIDTH`-bit unsigned sample since reset and continuously presents the truncated integer mean of all samples seen so far. Division runs on a parameterisable multicycle divider (`DIV_CYCLES`), so the same block serves both single-cycle and timing-relaxed builds with bit-identical results. It sits downstream of a sample stream and feeds status/monitoring logic that reads the mean once the stream goes quiet.

## Interface
- `WIDTH`, 8, sample and average width in bits (unsigned).
- `DIV_CYCLES`, 1, clock cycles per division. Legal range 1..`SUM_W`.
- `CNT_W`, 16, sample counter width; `SUM_W` = `WIDTH`+`CNT_W` (derived, not overridable).
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `data_in`  in  `WIDTH`  sample; sampled only when `dvalid`=1.
- `dvalid`  in  1  sample qualifier; one sample per cycle while high.
- `avg_out`  out  `WIDTH`  floor(sum/count) of all accepted samples; holds between updates.
- `avg_valid`  out  1  one-cycle pulse when `avg_out` takes a new result.

## Operation
- Accumulator: on each edge with `dvalid`=1 and count < 2^`CNT_W`-1, sum += `data_in` (zero-extended to `SUM_W`), count += 1, set `dirty`. Once count saturates, further samples are ignored: sum and count are frozen and `dirty` is not set. `SUM_W` guarantees no sum overflow.
- Divider FSM states:
  - IDLE: if `dirty`, latch snapshot (sum, count), clear `dirty`, go to BUSY.
  - BUSY: restoring divider retires ceil(`SUM_W`/`DIV_CYCLES`) quotient bits per cycle. After exactly `DIV_CYCLES` cycles, register the quotient's low `WIDTH` bits into `avg_out`, pulse `avg_valid`, return to IDLE.
- Samples arriving while BUSY only update the accumulator and set `dirty`. The in-flight division completes on its old snapshot, then a new division starts with the latest values. The final output therefore always reflects all accepted samples.
- Quotient always fits in `WIDTH` bits (mean ≤ max sample); upper quotient bits are zero by construction.
- Count = 0: no division is ever started; `avg_out` stays 0 and there is no divide-by-zero path.
- Division is truncating (floor). Results are identical for every `DIV_CYCLES` value.

## Timing
- Reset (async assert, sync-safe deassert): sum=0, count=0, `dirty`=0, FSM=IDLE, `avg_out`=0, `avg_valid`=0.
- Sample accepted at edge N → accumulator updated at N, `dirty` visible at N.
- If IDLE at edge N+1: snapshot at N+1, `avg_out`/`avg_valid` update at edge N+1+`DIV_CYCLES` (`DIV_CYCLES`=1 → latency 2 edges).
- Worst case after the last sample at edge N: final `avg_out` is valid by edge N+1+2·`DIV_CYCLES`; thereafter it is stable and `avg_valid` stays 0 until the next sample.
- Continuous `dvalid`: results update every `DIV_CYCLES`+1 cycles at most (back-to-back divisions, one IDLE cycle between).
- `rstn` asserted mid-division: in-flight division is discarded, all state returns to reset values immediately, and no `avg_valid` pulse is emitted.

## Test plan
- Reset: `rstn`=0 for 100 ns → `avg_out`=0 and `avg_valid`=0; no `avg_valid` pulse for 20 cycles with `dvalid`=0.
- Single sample 200 → `avg_out`=200 with one `avg_valid` pulse at edge N+1+`DIV_CYCLES`.
- Samples 10, 20, 31 back-to-back, then idle → final `avg_out`=20 (61/3 truncated).
- 100 random 8-bit samples at `dvalid`=1 every cycle, then 50 idle cycles → `avg_out` = floor(sum/100). Instances with `DIV_CYCLES`=1 and `DIV_CYCLES`=8 (and `SUM_W`) must agree.
- 255 repeated 1000 times → `avg_out`=255 (no overflow, quotient fits `WIDTH`).
- Reset asserted during BUSY with `DIV_CYCLES`=8 → outputs 0, no pulse. After release, sample 7 → `avg_out`=7.

Source files
------------

// File: rtl/sample_avg_core.sv
// Running mean of all accepted samples since reset, computed by a restoring
// divider that retires ceil(SUM_W/DIV_CYCLES) quotient bits per cycle.
module sample_avg_core #(
  parameter int WIDTH      = 8,
  parameter int DIV_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dvalid,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid
);

  localparam int SUM_W  = WIDTH + CNT_W;
  localparam int BPC    = (SUM_W + DIV_CYCLES - 1) / DIV_CYCLES;
  localparam int TOT_W  = BPC * DIV_CYCLES;
  localparam int STEP_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dirty_q, dirty_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [TOT_W-1:0]   quo_q, quo_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   avg_q, avg_d;
  logic               avg_valid_q, avg_valid_d;

  logic               accept;
  logic [CNT_W:0]     rem_s;
  logic [TOT_W-1:0]   quo_s;

  // Dividend bits shift out of the top of quo while quotient bits shift in at the bottom.
  always_comb begin
    rem_s = rem_q;
    quo_s = quo_q;
    for (int i = 0; i < BPC; i++) begin
      rem_s = {rem_s[CNT_W-1:0], quo_s[TOT_W-1]};
      quo_s = {quo_s[TOT_W-2:0], 1'b0};
      if (rem_s >= {1'b0, div_q}) begin
        rem_s    = rem_s - {1'b0, div_q};
        quo_s[0] = 1'b1;
      end
    end
  end

  always_comb begin
    accept      = dvalid && (cnt_q != {CNT_W{1'b1}});
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    dirty_d     = dirty_q;
    state_d     = state_q;
    step_d      = step_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    div_d       = div_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          quo_d   = TOT_W'(sum_q);
          rem_d   = '0;
          div_d   = cnt_q;
          step_d  = '0;
          dirty_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        quo_d = quo_s;
        rem_d = rem_s;
        if (step_q == STEP_W'(DIV_CYCLES - 1)) begin
          avg_d       = quo_s[WIDTH-1:0];
          avg_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A sample landing on the snapshot edge must still re-arm the next division.
    if (accept) begin
      sum_d   = sum_q + SUM_W'(data_in);
      cnt_d   = cnt_q + 1'b1;
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      dirty_q     <= 1'b0;
      step_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      dirty_q     <= dirty_d;
      step_q      <= step_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_sample_avg_core.sv
// Drives three divider configurations (1, 8 and SUM_W cycles) with identical
// streams and checks each against bench-computed means.
module tb_sample_avg_core;

  localparam int NI = 3;

  typedef struct packed {
    int              nvals;
    logic [3:0][7:0] vals;
    int              reps;
    int              exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dvalid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] avg_out_w [NI];
  logic       avg_valid_w [NI];

  int dcs [NI] = '{1, 8, 24};
  int pulses [NI] = '{0, 0, 0};
  int last_cyc [NI] = '{0, 0, 0};
  int base [NI];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q [$];
  vec_t vecs [7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_avg_core #(.WIDTH(8), .DIV_CYCLES(1), .CNT_W(16)) u_dc1 (
    .clk(clk), .rstn(rstn), .data_in(data_in), .dvalid(dvalid),
    .avg_out(avg_out_w[0]), .avg_valid(avg_valid_w[0]));
  sample_avg_core #(.WIDTH(8), .DIV_CYCLES(8), .CNT_W(16)) u_dc8 (
    .clk(clk), .rstn(rstn), .data_in(data_in), .dvalid(dvalid),
    .avg_out(avg_out_w[1]), .avg_valid(avg_valid_w[1]));
  sample_avg_core #(.WIDTH(8), .DIV_CYCLES(24), .CNT_W(16)) u_dc24 (
    .clk(clk), .rstn(rstn), .data_in(data_in), .dvalid(dvalid),
    .avg_out(avg_out_w[2]), .avg_valid(avg_valid_w[2]));

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (avg_valid_w[i] === 1'b1) begin
        pulses[i]   <= pulses[i] + 1;
        last_cyc[i] <= cyc;
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dc=%0d]: got %0d, expected %0d", name, dcs[inst], act, exp);
    end else begin
      $display("ok   %s [dc=%0d]: %0d", name, dcs[inst], act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn   = 1'b0;
    dvalid = 1'b0;
    #100;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send(input logic [7:0] v);
    data_in = v;
    dvalid  = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    dvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic take_base();
    for (int i = 0; i < NI; i++) base[i] = pulses[i];
  endtask

  // Let every instance settle, then confirm the result and that outputs are quiet.
  task automatic settle_and_check(input string name);
    int e;
    idle(50);
    take_base();
    idle(10);
    e = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk({name, " avg"}, i, int'(avg_out_w[i]), e);
      chk({name, " quiet"}, i, pulses[i] - base[i], 0);
    end
  endtask

  initial begin
    int acc;
    int sum;
    logic [7:0] v;

    vecs[0] = '{nvals: 1, vals: {8'd0, 8'd0, 8'd0, 8'd200}, reps: 1, exp: 200};
    vecs[1] = '{nvals: 3, vals: {8'd0, 8'd31, 8'd20, 8'd10}, reps: 1, exp: 20};
    vecs[2] = '{nvals: 1, vals: {8'd0, 8'd0, 8'd0, 8'd255}, reps: 1000, exp: 255};
    vecs[3] = '{nvals: 2, vals: {8'd0, 8'd0, 8'd2, 8'd1}, reps: 1, exp: 1};
    vecs[4] = '{nvals: 4, vals: {8'd0, 8'd0, 8'd0, 8'd1}, reps: 1, exp: 0};
    vecs[5] = '{nvals: 4, vals: {8'd253, 8'd252, 8'd251, 8'd250}, reps: 3, exp: 251};
    vecs[6] = '{nvals: 2, vals: {8'd0, 8'd0, 8'd255, 8'd0}, reps: 1, exp: 127};

    // Reset state and silence with no samples.
    #100;
    for (int i = 0; i < NI; i++) begin
      chk("in_reset avg", i, int'(avg_out_w[i]), 0);
      chk("in_reset valid", i, int'(avg_valid_w[i]), 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    take_base();
    idle(20);
    for (int i = 0; i < NI; i++) begin
      chk("no_sample pulses", i, pulses[i] - base[i], 0);
      chk("no_sample avg", i, int'(avg_out_w[i]), 0);
    end

    // Single sample: exact pulse edge and a single pulse.
    do_reset();
    take_base();
    exp_q.push_back(200);
    send(8'd200);
    acc = cyc;
    idle(60);
    v = 8'(exp_q.pop_front());
    for (int i = 0; i < NI; i++) begin
      chk("single pulses", i, pulses[i] - base[i], 1);
      chk("single latency", i, last_cyc[i], acc + 1 + dcs[i]);
      chk("single avg", i, int'(avg_out_w[i]), int'(v));
    end

    // Table-driven streams.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      exp_q.push_back(vecs[t].exp);
      for (int r = 0; r < vecs[t].reps; r++)
        for (int k = 0; k < vecs[t].nvals; k++)
          send(vecs[t].vals[k]);
      settle_and_check($sformatf("vec%0d", t));
    end

    // Random continuous stream.
    do_reset();
    sum = 0;
    for (int k = 0; k < 100; k++) begin
      v = 8'($urandom_range(0, 255));
      sum += int'(v);
      send(v);
    end
    exp_q.push_back(sum / 100);
    settle_and_check("random100");

    // Reset while the slower instances are mid-division.
    do_reset();
    send(8'd100);
    idle(2);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("busy_reset avg", i, int'(avg_out_w[i]), 0);
      chk("busy_reset valid", i, int'(avg_valid_w[i]), 0);
    end
    #30;
    @(negedge clk);
    rstn = 1'b1;
    take_base();
    idle(30);
    for (int i = 0; i < NI; i++) begin
      chk("post_reset pulses", i, pulses[i] - base[i], 0);
      chk("post_reset avg", i, int'(avg_out_w[i]), 0);
    end
    exp_q.push_back(7);
    send(8'd7);
    settle_and_check("after_reset7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
